exc_commit_ctrl: RTL and testbench

//  Commit-stage exception/interrupt/ERET sequencer feeding the CP0 exp_* port.

---
 rtl/sirius_exc_pkg.sv | 18 +
 rtl/exc_prio_enc.sv | 26 ++
 rtl/exc_commit_ctrl.sv | 102 ++++++++++
 tb/tb_exc_commit_ctrl.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sirius_exc_pkg.sv
// sirius_exc_pkg: exception codes, commit_exc bit layout and sequencer states shared by the commit controller
package sirius_exc_pkg;
  typedef enum logic [4:0] {
    EXC_INT = 5'd0, EXC_MOD = 5'd1, EXC_TLBL = 5'd2, EXC_TLBS = 5'd3, EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5, EXC_SYS = 5'd8, EXC_BP = 5'd9, EXC_RI = 5'd10, EXC_CPU = 5'd11,
    EXC_OV = 5'd12, EXC_TR = 5'd13
  } exc_code_t;
  // commit_exc bit positions, lowest index = highest priority.
  // AdEL is one flag for fetch and load: a load cannot also raise RI..Tr, so one slot is exact.
  localparam int B_ADEL = 0, B_ITLBL = 1, B_RI = 2, B_CPU = 3, B_SYS = 4, B_BP = 5;
  localparam int B_OV = 6, B_TR = 7, B_ADES = 8, B_DTLBL = 9, B_DTLBS = 10, B_MOD = 11;
  localparam exc_code_t BIT_CODE [12] = '{
    EXC_ADEL, EXC_TLBL, EXC_RI, EXC_CPU, EXC_SYS, EXC_BP,
    EXC_OV, EXC_TR, EXC_ADES, EXC_TLBL, EXC_TLBS, EXC_MOD
  };
  localparam logic [11:0] ADDR_MASK = 12'b1111_0000_0011;
  typedef enum logic [1:0] {IDLE, FLUSH, REDIRECT} state_t;
endpackage

// File: rtl/exc_prio_enc.sv
// exc_prio_enc: picks the winning event of a committing instruction
//   in: exc[11:0] fault flags, intr qualified interrupt, eret
//   out: hit any event, code winning ExcCode, is_addr loads BadVAddr, is_eret ERET wins
module exc_prio_enc
  import sirius_exc_pkg::*;
(
  input  logic [11:0] exc,
  input  logic        intr,
  input  logic        eret,
  output logic        hit,
  output logic [4:0]  code,
  output logic        is_addr,
  output logic        is_eret
);
  always_comb begin
    hit = intr | (|exc) | eret;
    is_eret = ~intr & ~(|exc) & eret;
    code = EXC_INT;
    is_addr = 1'b0;
    for (int i = 11; i >= 0; i--)
      if (!intr && exc[i]) begin
        code = BIT_CODE[i];
        is_addr = ADDR_MASK[i];
      end
  end
endmodule

// File: rtl/exc_commit_ctrl.sv
// exc_commit_ctrl: commit-stage exception/interrupt/ERET sequencer driving CP0 exp_* and the fetch redirect
//   commit_*: instruction at commit (valid/ready handshake, pc, bd, faults, refill, badvaddr, eret)
//   allow_interrupt, interrupt_flag, exl_set, use_*_iv, ebase_address, epc_address: CP0 state
//   exp_*, exl_clean: one-cycle CP0 update; flush: kill younger state; redirect_*: PC to fetch
module exc_commit_ctrl
  import sirius_exc_pkg::*;
#(
  parameter logic [31:0] BOOT_BASE   = 32'hBFC00200,
  parameter logic [31:0] REFILL_OFF  = 32'h000,
  parameter logic [31:0] GENERAL_OFF = 32'h180,
  parameter logic [31:0] INT_OFF     = 32'h200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        commit_valid,
  output logic        commit_ready,
  input  logic [31:0] commit_pc,
  input  logic        commit_bd,
  input  logic [11:0] commit_exc,
  input  logic        commit_refill,
  input  logic [31:0] commit_badvaddr,
  input  logic        commit_eret,
  input  logic        allow_interrupt,
  input  logic [7:0]  interrupt_flag,
  input  logic        exl_set,
  input  logic        use_special_iv,
  input  logic        use_bootstrap_iv,
  input  logic [31:0] ebase_address,
  input  logic [31:0] epc_address,
  output logic        exp_en,
  output logic        exp_badvaddr_en,
  output logic        exp_bd,
  output logic        exl_clean,
  output logic        exp_asid_en,
  output logic [4:0]  exp_code,
  output logic [31:0] exp_epc,
  output logic [31:0] exp_badvaddr,
  output logic [7:0]  exp_asid,
  output logic        flush,
  output logic        redirect_valid,
  input  logic        redirect_ready,
  output logic [31:0] redirect_pc
);
  state_t state, state_n;
  logic hit, is_addr, is_eret, intr, take, tlb, holdoff, bva_en_q, exl_clean_q, bd_q;
  logic [4:0] code, code_q;
  logic [31:0] vector, bva_q, epc_q, pc_q;
  // CP0 Status lags the ERET/handler return by a cycle, so the first IDLE cycle ignores interrupts.
  assign intr = allow_interrupt & (|interrupt_flag) & ~holdoff;
  exc_prio_enc u_enc (
    .exc(commit_exc), .intr(intr), .eret(commit_eret),
    .hit(hit), .code(code), .is_addr(is_addr), .is_eret(is_eret)
  );
  assign take = (state == IDLE) & commit_valid & hit;
  assign tlb = (code == EXC_TLBL) | (code == EXC_TLBS);
  assign vector = (use_bootstrap_iv ? BOOT_BASE : ebase_address) +
                  (tlb & commit_refill & ~exl_set ? REFILL_OFF :
                   (code == EXC_INT) & use_special_iv ? INT_OFF : GENERAL_OFF);
  always_comb begin
    state_n = state == IDLE ? (take ? FLUSH : IDLE) : (redirect_ready ? IDLE : REDIRECT);
    commit_ready = (state == IDLE) & ~take;
    exp_en = state == FLUSH;
    flush = state == FLUSH;
    redirect_valid = state != IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      holdoff <= 1'b0;
      code_q <= '0;
      bd_q <= 1'b0;
      bva_q <= '0;
      epc_q <= '0;
      pc_q <= '0;
      bva_en_q <= 1'b0;
      exl_clean_q <= 1'b0;
    end else begin
      state <= state_n;
      holdoff <= (state != IDLE) & redirect_ready;
      if (take) begin
        pc_q <= is_eret ? epc_address : vector;
        epc_q <= is_eret ? epc_address : commit_bd ? commit_pc - 32'd4 : commit_pc;
        exl_clean_q <= is_eret;
        bva_en_q <= is_addr;
        if (!is_eret) begin
          code_q <= code;
          bd_q <= commit_bd;
        end
        if (is_addr) bva_q <= commit_badvaddr;
      end
    end
  end
  assign exp_code = code_q;
  assign exp_bd = bd_q;
  assign exp_epc = epc_q;
  assign exp_badvaddr = bva_q;
  assign exp_badvaddr_en = exp_en & bva_en_q;
  assign exl_clean = exp_en & exl_clean_q;
  assign exp_asid_en = 1'b0;
  assign exp_asid = '0;
  assign redirect_pc = pc_q;
endmodule

// File: tb/tb_exc_commit_ctrl.sv
// tb_exc_commit_ctrl: directed and randomized checks of exc_commit_ctrl against a priority-list reference model
module tb_exc_commit_ctrl;
  logic clk = 0, rst = 1, commit_valid = 0, commit_ready, commit_bd = 0, commit_refill = 0, commit_eret = 0;
  logic [31:0] commit_pc = 0, commit_badvaddr = 0, ebase_address = 32'h80000000, epc_address = 0;
  logic [11:0] commit_exc = 0;
  logic allow_interrupt = 0, exl_set = 0, use_special_iv = 0, use_bootstrap_iv = 0, redirect_ready = 1;
  logic [7:0] interrupt_flag = 0, exp_asid;
  logic exp_en, exp_badvaddr_en, exp_bd, exl_clean, exp_asid_en, flush, redirect_valid;
  logic [4:0] exp_code;
  logic [31:0] exp_epc, exp_badvaddr, redirect_pc;
  int n_checks = 0, n_fail = 0;
  exc_commit_ctrl dut (
    .clk(clk), .rst(rst), .commit_valid(commit_valid), .commit_ready(commit_ready),
    .commit_pc(commit_pc), .commit_bd(commit_bd), .commit_exc(commit_exc),
    .commit_refill(commit_refill), .commit_badvaddr(commit_badvaddr), .commit_eret(commit_eret),
    .allow_interrupt(allow_interrupt), .interrupt_flag(interrupt_flag), .exl_set(exl_set),
    .use_special_iv(use_special_iv), .use_bootstrap_iv(use_bootstrap_iv),
    .ebase_address(ebase_address), .epc_address(epc_address), .exp_en(exp_en),
    .exp_badvaddr_en(exp_badvaddr_en), .exp_bd(exp_bd), .exl_clean(exl_clean),
    .exp_asid_en(exp_asid_en), .exp_code(exp_code), .exp_epc(exp_epc),
    .exp_badvaddr(exp_badvaddr), .exp_asid(exp_asid), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_ready(redirect_ready), .redirect_pc(redirect_pc)
  );
  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  function automatic void ref_model(input logic [11:0] e, input logic intr, input logic er,
                                    output logic hit, output int code, output logic addr);
    int codes [12] = '{4, 2, 10, 11, 8, 9, 12, 13, 5, 2, 3, 1};
    int b = 0;
    hit = intr || e != 0 || er;
    code = 0;
    addr = 0;
    if (!intr && e != 0) begin
      while (!e[b]) b++;
      code = codes[b];
      addr = b inside {0, 1, 8, 9, 10, 11};
    end
  endfunction
  function automatic logic [31:0] ref_vec(input int code, input logic refill, input logic exl,
                                          input logic boot, input logic special, input logic [31:0] ebase);
    logic [31:0] base = boot ? 32'hBFC00200 : ebase;
    if ((code == 2 || code == 3) && refill && !exl) return base;
    if (code == 0 && special) return base + 32'h200;
    return base + 32'h180;
  endfunction
  task automatic fire(input logic [11:0] e, input logic bd, input logic refill, input logic er,
                      input logic [31:0] pc, input logic [31:0] bva, output logic rdy);
    @(negedge clk);
    commit_exc = e; commit_bd = bd; commit_refill = refill; commit_eret = er;
    commit_pc = pc; commit_badvaddr = bva; commit_valid = 1;
    #1 rdy = commit_ready;
    @(posedge clk);
    #1 commit_valid = 0; commit_exc = 0; commit_eret = 0;
    @(negedge clk);
  endtask
  task automatic test_reset;
    rst = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({commit_ready, exp_en, flush, redirect_valid, exp_badvaddr_en, exl_clean} !== 6'b100000) begin
      n_fail++; $display("FAIL reset_ctrl got %b want 100000",
        {commit_ready, exp_en, flush, redirect_valid, exp_badvaddr_en, exl_clean});
    end
    n_checks++;
    if ({exp_code, exp_bd, exp_badvaddr, exp_epc} !== '0) begin
      n_fail++; $display("FAIL reset_regs got code %h bd %b bva %h epc %h want 0", exp_code, exp_bd, exp_badvaddr, exp_epc);
    end
    rst = 0;
  endtask
  task automatic test_sys;
    logic r;
    redirect_ready = 1;
    fire(12'h010, 0, 0, 0, 32'h80001000, 0, r);
    n_checks++;
    if (r !== 0) begin n_fail++; $display("FAIL sys_ready got %b want 0", r); end
    n_checks++;
    if ({exp_en, flush, redirect_valid, exp_badvaddr_en, exl_clean, exp_bd} !== 6'b111000) begin
      n_fail++; $display("FAIL sys_ctrl got %b want 111000", {exp_en, flush, redirect_valid, exp_badvaddr_en, exl_clean, exp_bd});
    end
    n_checks++;
    if ({exp_code, exp_epc, redirect_pc} !== {5'd8, 32'h80001000, 32'h80000180}) begin
      n_fail++; $display("FAIL sys_data got code %0d epc %h pc %h want 8 80001000 80000180", exp_code, exp_epc, redirect_pc);
    end
    @(negedge clk);
    n_checks++;
    if ({exp_en, flush, redirect_valid, commit_ready} !== 4'b0001) begin
      n_fail++; $display("FAIL sys_one_cycle got %b want 0001", {exp_en, flush, redirect_valid, commit_ready});
    end
    @(posedge clk);
  endtask
  task automatic test_fetch_adel;
    logic r;
    fire(12'h001, 1, 0, 0, 32'h80002004, 32'h00400003, r);
    n_checks++;
    if ({exp_en, exp_code, exp_epc, exp_bd, exp_badvaddr_en, exp_badvaddr} !==
        {1'b1, 5'd4, 32'h80002000, 1'b1, 1'b1, 32'h00400003}) begin
      n_fail++; $display("FAIL adel got en %b code %0d epc %h bd %b bva_en %b bva %h want 1 4 80002000 1 1 00400003",
        exp_en, exp_code, exp_epc, exp_bd, exp_badvaddr_en, exp_badvaddr);
    end
    repeat (2) @(posedge clk);
  endtask
  task automatic test_refill;
    logic r;
    logic [31:0] want [3] = '{32'h80000000, 32'h80000180, 32'hBFC00200};
    for (int i = 0; i < 3; i++) begin
      exl_set = i == 1;
      use_bootstrap_iv = i == 2;
      fire(12'h002, 0, 1, 0, 32'h80005000 + 32'(i * 4), 32'h00700000 + 32'(i), r);
      n_checks++;
      if ({exp_code, redirect_pc} !== {5'd2, want[i]}) begin
        n_fail++; $display("FAIL refill_%0d got code %0d pc %h want 2 %h", i, exp_code, redirect_pc, want[i]);
      end
      repeat (2) @(posedge clk);
    end
    exl_set = 0;
    use_bootstrap_iv = 0;
  endtask
  task automatic test_int;
    logic r;
    allow_interrupt = 1;
    interrupt_flag = 8'h04;
    for (int i = 0; i < 2; i++) begin
      use_special_iv = i == 1;
      fire(12'h004, 0, 0, 0, 32'h80006000, 0, r);
      n_checks++;
      if ({r, exp_en, exp_code, exp_badvaddr_en, redirect_pc} !==
          {2'b01, 5'd0, 1'b0, i == 1 ? 32'h80000200 : 32'h80000180}) begin
        n_fail++; $display("FAIL int_%0d got rdy %b en %b code %0d bva_en %b pc %h", i, r, exp_en, exp_code, exp_badvaddr_en, redirect_pc);
      end
      repeat (2) @(posedge clk);
    end
    allow_interrupt = 0;
    interrupt_flag = 0;
    use_special_iv = 0;
  endtask
  task automatic test_eret_hold;
    logic r;
    fire(12'h100, 0, 0, 0, 32'h80007000, 32'h12345678, r);
    repeat (2) @(posedge clk);
    fire(12'h010, 0, 0, 0, 32'h80004000, 32'hdeadbeef, r);
    repeat (2) @(posedge clk);
    epc_address = 32'h80003000;
    redirect_ready = 0;
    fire(12'h000, 1, 0, 1, 32'h80008000, 0, r);
    epc_address = 32'h90000000;
    n_checks++;
    if ({r, exp_en, exl_clean, exp_code, exp_bd, exp_badvaddr_en} !== {2'b01, 1'b1, 5'd8, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL eret_ctrl got rdy %b en %b clean %b code %0d bd %b bva_en %b want 0 1 1 8 0 0",
        r, exp_en, exl_clean, exp_code, exp_bd, exp_badvaddr_en);
    end
    n_checks++;
    if ({exp_epc, redirect_pc, exp_badvaddr} !== {32'h80003000, 32'h80003000, 32'h12345678}) begin
      n_fail++; $display("FAIL eret_data got epc %h pc %h bva %h want 80003000 80003000 12345678", exp_epc, redirect_pc, exp_badvaddr);
    end
    allow_interrupt = 1;
    interrupt_flag = 8'h04;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if ({redirect_valid, exp_en, commit_ready, redirect_pc} !== {3'b100, 32'h80003000}) begin
        n_fail++; $display("FAIL eret_hold_%0d got rv %b en %b rdy %b pc %h want 1 0 0 80003000", i, redirect_valid, exp_en, commit_ready, redirect_pc);
      end
    end
    redirect_ready = 1;
    @(posedge clk);
    #1 redirect_ready = 0;
    commit_exc = 0; commit_eret = 0; commit_bd = 0; commit_pc = 32'h80003000; commit_valid = 1;
    @(negedge clk);
    n_checks++;
    if ({commit_ready, redirect_valid} !== 2'b10) begin
      n_fail++; $display("FAIL holdoff got rdy %b rv %b want 1 0", commit_ready, redirect_valid);
    end
    @(negedge clk);
    n_checks++;
    if (commit_ready !== 0) begin n_fail++; $display("FAIL int_after_holdoff got rdy %b want 0", commit_ready); end
    @(posedge clk);
    #1 commit_valid = 0;
    @(negedge clk);
    n_checks++;
    if ({exp_en, exp_code, exp_epc, redirect_pc} !== {1'b1, 5'd0, 32'h80003000, 32'h80000180}) begin
      n_fail++; $display("FAIL int_taken got en %b code %0d epc %h pc %h want 1 0 80003000 80000180", exp_en, exp_code, exp_epc, redirect_pc);
    end
    redirect_ready = 1;
    allow_interrupt = 0;
    interrupt_flag = 0;
    repeat (2) @(posedge clk);
  endtask
  task automatic test_rst_redirect;
    logic r;
    redirect_ready = 0;
    fire(12'h020, 0, 0, 0, 32'h80009000, 0, r);
    @(negedge clk);
    n_checks++;
    if ({redirect_valid, exp_en} !== 2'b10) begin
      n_fail++; $display("FAIL in_redirect got rv %b en %b want 1 0", redirect_valid, exp_en);
    end
    rst = 1;
    @(negedge clk);
    n_checks++;
    if ({redirect_valid, commit_ready, exp_en, flush, exp_code} !== {4'b0100, 5'd0}) begin
      n_fail++; $display("FAIL rst_redirect got rv %b rdy %b en %b flush %b code %0d want 0 1 0 0 0",
        redirect_valid, commit_ready, exp_en, flush, exp_code);
    end
    rst = 0;
    redirect_ready = 1;
  endtask
  task automatic test_random;
    logic r, hit, addr, intr, bd, refill, er;
    logic [11:0] e;
    logic [31:0] pc, bva, vec;
    logic [4:0] m_code = 0;
    logic m_bd = 0;
    logic [31:0] m_bva = 0;
    int code;
    redirect_ready = 1;
    for (int it = 0; it < 60; it++) begin
      e = 0;
      if ($urandom_range(0, 2) != 0) e[$urandom_range(0, 11)] = 1;
      if ($urandom_range(0, 1) != 0) e[$urandom_range(0, 11)] = 1;
      allow_interrupt = 1'($urandom_range(0, 1));
      interrupt_flag = $urandom_range(0, 2) == 0 ? 8'h00 : 8'($urandom);
      er = $urandom_range(0, 3) == 0;
      bd = 1'($urandom);
      refill = 1'($urandom);
      exl_set = 1'($urandom);
      use_special_iv = 1'($urandom);
      use_bootstrap_iv = 1'($urandom);
      ebase_address = {2'b10, 18'($urandom), 12'h000};
      epc_address = $urandom & 32'hfffffffc;
      pc = $urandom & 32'hfffffffc;
      bva = $urandom;
      intr = allow_interrupt && interrupt_flag != 0;
      ref_model(e, intr, er, hit, code, addr);
      vec = ref_vec(code, refill, exl_set, use_bootstrap_iv, use_special_iv, ebase_address);
      fire(e, bd, refill, er, pc, bva, r);
      n_checks++;
      if (r !== !hit) begin n_fail++; $display("FAIL rnd_ready_%0d got %b want %b", it, r, !hit); end
      if (!hit) begin
        n_checks++;
        if ({exp_en, redirect_valid} !== 2'b00) begin
          n_fail++; $display("FAIL rnd_idle_%0d got en %b rv %b want 0 0", it, exp_en, redirect_valid);
        end
      end else if (!intr && e == 0) begin
        n_checks++;
        if ({exp_en, flush, exl_clean, exp_badvaddr_en, exp_code, exp_bd, exp_badvaddr, exp_epc, redirect_pc} !==
            {4'b1110, m_code, m_bd, m_bva, epc_address, epc_address}) begin
          n_fail++; $display("FAIL rnd_eret_%0d got en %b clean %b code %0d bd %b bva %h epc %h pc %h want code %0d bd %b bva %h epc/pc %h",
            it, exp_en, exl_clean, exp_code, exp_bd, exp_badvaddr, exp_epc, redirect_pc, m_code, m_bd, m_bva, epc_address);
        end
      end else begin
        m_code = 5'(code);
        m_bd = bd;
        if (addr) m_bva = bva;
        n_checks++;
        if ({exp_en, flush, exl_clean, exp_badvaddr_en, exp_code, exp_bd, exp_badvaddr, exp_epc, redirect_pc} !==
            {3'b110, addr, m_code, m_bd, m_bva, bd ? pc - 32'd4 : pc, vec}) begin
          n_fail++; $display("FAIL rnd_exc_%0d got en %b clean %b bva_en %b code %0d bd %b bva %h epc %h pc %h want bva_en %b code %0d bd %b bva %h pc %h",
            it, exp_en, exl_clean, exp_badvaddr_en, exp_code, exp_bd, exp_badvaddr, exp_epc, redirect_pc, addr, m_code, m_bd, m_bva, vec);
        end
      end
      repeat (2) @(posedge clk);
    end
    allow_interrupt = 0;
    interrupt_flag = 0;
    exl_set = 0;
    use_special_iv = 0;
    use_bootstrap_iv = 0;
    ebase_address = 32'h80000000;
  endtask
  initial begin
    test_reset;
    test_sys;
    test_fetch_adel;
    test_refill;
    test_int;
    test_eret_hold;
    test_rst_redirect;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
